alu_bist_seq: RTL and testbench
===============================

ALU_BIST_SEQ -- requirements
Module: alu_bist_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, DUT settle cycles between drive and capture, legal range 1..15.
REQ-002 Parameter SEED, default 16'hFFFF, signature value loaded at reset and at each start.
REQ-003 Parameter EXPECTED_SIG, default 16'h0000, golden signature used by the pass check.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a full sweep.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  high from sweep completion until next accepted start or reset.
REQ-009 a_out, b_out, s_out  output  4 each  ALU operand A, operand B, function select.
REQ-010 m_out  output  1  ALU mode (1 = logic, 0 = arithmetic).
REQ-011 ci_n_out  output  1  ALU active-low carry-in.
REQ-012 y_in  input  4  ALU function result.
REQ-013 p_in, q_in, co_n_in, aeqb_in  input  1 each  ALU propagate, generate, active-low carry-out, A=B.
REQ-014 signature  output  16  MISR contents.
REQ-015 vec_cnt  output  14  index of the vector currently driven.
REQ-016 pass  output  1  signature-match flag (see Configuration).

Function
REQ-017 States: IDLE, DRIVE, WAIT, CAPTURE, DONE.
REQ-018 IDLE/DONE + start=1 -> DRIVE next cycle; vec_cnt <= 0, signature <= SEED, done <= 0, busy <= 1.
REQ-019 start is ignored in DRIVE, WAIT and CAPTURE.
REQ-020 ALU inputs are registered from vec_cnt: a_out=vec_cnt[3:0], b_out=vec_cnt[7:4], s_out=vec_cnt[11:8], m_out=vec_cnt[12], ci_n_out=vec_cnt[13]; a varies fastest.
REQ-021 DRIVE lasts 1 cycle -> WAIT; WAIT lasts exactly SETTLE_CYCLES cycles (internal 4-bit counter) -> CAPTURE.
REQ-022 CAPTURE lasts 1 cycle and samples resp = {y_in, p_in, q_in, co_n_in, aeqb_in} (8 bits, y_in in MSBs).
REQ-023 MISR update in CAPTURE: t = {signature[14:0],1'b0}; t ^= 16'h1021 when signature[15]=1; signature <= t ^ {8'h00, resp}.
REQ-024 CAPTURE with vec_cnt < 16383 -> vec_cnt increments, DRIVE; with vec_cnt = 16383 -> DONE, busy <= 0, done <= 1, vec_cnt holds 16383 (no wrap).
REQ-025 Per-vector period SETTLE_CYCLES+2 cycles; full sweep 16384*(SETTLE_CYCLES+2) cycles from first DRIVE to DONE.
REQ-026 signature and vec_cnt hold their values in DONE until the next accepted start.

Reset
REQ-027 rst_n=0 at a rising edge -> IDLE; busy=0, done=0, pass=0, vec_cnt=0, a/b/s_out=0, m_out=0, ci_n_out=0, signature=SEED, settle counter=0.
REQ-028 Reset mid-sweep aborts immediately with the values of REQ-027; no partial signature is retained.
REQ-029 Reset asserted together with start: reset wins.

Configuration
REQ-030 Macro ALU_BIST_PASS_CHECK_EN defined: pass <= (signature == EXPECTED_SIG) registered on entry to DONE, cleared on accepted start or reset.
REQ-031 Macro ALU_BIST_PASS_CHECK_EN undefined: comparator absent, pass tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, no start -> all outputs 0 except signature=16'hFFFF; 100 idle cycles leave them unchanged.
REQ-033 SETTLE_CYCLES=1, start pulse -> busy=1 next cycle; a_out=0 then a_out=1 three cycles later; b_out=1 at vector 16; s_out=1 at vector 256; m_out=1 at vector 4096; ci_n_out=1 at vector 8192.
REQ-034 SEED=16'hFFFF, resp tied 8'h00 -> signature=16'hEFDF after first CAPTURE; SEED=16'h0000, resp tied 8'hFF -> signature=16'h00FF after first CAPTURE.
REQ-035 Full sweep with SETTLE_CYCLES=1 -> done=1 exactly 49152 cycles after first DRIVE, vec_cnt=16383; start pulses mid-sweep have no effect.
REQ-036 rst_n=0 at vector 5000 -> next cycle IDLE, signature=SEED, vec_cnt=0; new start reruns identically to REQ-035 with identical final signature.
REQ-037 With ALU_BIST_PASS_CHECK_EN and EXPECTED_SIG set to the signature of a correct ALU model -> pass=1 in DONE; one forced Y bit error -> pass=0; without the macro -> pass=0 always.

Source files
------------

// File: rtl/alu_bist_seq.sv
// alu_bist_seq: exhaustive BIST sequencer for a 4-bit 74181-style ALU.
// Sweeps all 16384 {ci_n, m, s, b, a} combinations. Each vector is driven,
// allowed to settle, and then its 8-bit response is folded into a 16-bit MISR.
// Optional feature macro: ALU_BIST_PASS_CHECK_EN. When it is defined, the
// final signature is compared with EXPECTED_SIG and the result drives pass.
module alu_bist_seq #(
  parameter int          SETTLE_CYCLES = 1,        // legal 1..15
  parameter logic [15:0] SEED          = 16'hFFFF,
  parameter logic [15:0] EXPECTED_SIG  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  a_out,
  output logic [3:0]  b_out,
  output logic [3:0]  s_out,
  output logic        m_out,
  output logic        ci_n_out,
  input  logic [3:0]  y_in,
  input  logic        p_in,
  input  logic        q_in,
  input  logic        co_n_in,
  input  logic        aeqb_in,
  output logic [15:0] signature,
  output logic [13:0] vec_cnt,
  output logic        pass
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [13:0] VEC_LAST    = 14'h3FFF;

  state_t      r_state, w_state_nxt;
  logic [13:0] r_vec;
  logic [13:0] r_drv;      // vector currently presented on the ALU pins
  logic [15:0] r_sig;
  logic [3:0]  r_settle;
  logic        r_busy, r_done;

  logic        w_accept, w_capture, w_last;
  logic [7:0]  w_resp;
  logic [15:0] w_shift, w_misr;
  logic [13:0] w_vec_inc;

  // Response byte and next MISR value (CRC-CCITT feedback, response in low byte)
  always_comb begin
    w_resp    = {y_in, p_in, q_in, co_n_in, aeqb_in};
    w_shift   = {r_sig[14:0], 1'b0};
    if (r_sig[15]) w_shift = w_shift ^ 16'h1021;
    w_misr    = w_shift ^ {8'h00, w_resp};
    w_vec_inc = r_vec + 14'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and phase strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_last      = (r_vec == VEC_LAST);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_settle == SETTLE_LAST) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_DRIVE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Settle counter: counts the cycles spent in WAIT, otherwise parked at 0
  always_ff @(posedge clk) begin
    if (!rst_n)                                         r_settle <= 4'd0;
    else if (r_state == S_WAIT && r_settle != SETTLE_LAST) r_settle <= r_settle + 4'd1;
    else                                                r_settle <= 4'd0;
  end

  // Sweep datapath: vector index, driven pins, signature, status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec  <= 14'd0;
      r_drv  <= 14'd0;
      r_sig  <= SEED;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_accept) begin
      r_vec  <= 14'd0;
      r_drv  <= 14'd0;
      r_sig  <= SEED;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (w_capture) begin
      r_sig <= w_misr;
      if (w_last) begin
        // index holds at the last vector; no wrap
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_vec <= w_vec_inc;
        r_drv <= w_vec_inc;
      end
    end
  end

`ifdef ALU_BIST_PASS_CHECK_EN
  logic r_pass;

  // Golden compare of the final signature, latched on the way into DONE
  always_ff @(posedge clk) begin
    if (!rst_n)                   r_pass <= 1'b0;
    else if (w_accept)            r_pass <= 1'b0;
    else if (w_capture && w_last) r_pass <= (w_misr == EXPECTED_SIG);
  end

  assign pass = r_pass;
`else
  assign pass = 1'b0;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign vec_cnt   = r_vec;
  assign a_out     = r_drv[3:0];
  assign b_out     = r_drv[7:4];
  assign s_out     = r_drv[11:8];
  assign m_out     = r_drv[12];
  assign ci_n_out  = r_drv[13];

endmodule

// File: tb/tb_alu_bist_seq.sv
// Self-checking bench for alu_bist_seq. The DUT drives a behavioural ALU
// model. Outside the capture cycle the bench places random noise on the
// response pins. A sweep-level reference model predicts every output on every
// cycle.
module tb_alu_bist_seq;
  localparam int          SETTLE = 1;
  localparam int          P      = SETTLE + 2;
  localparam logic [15:0] SEED   = 16'hFFFF;
  localparam logic [15:0] EXP    = 16'h0000;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, done, m_out, ci_n_out, pass;
  logic [3:0]  a_out, b_out, s_out, y_in;
  logic        p_in, q_in, co_n_in, aeqb_in;
  logic [15:0] signature;
  logic [13:0] vec_cnt;

  int checks = 0, failures = 0;
  int fault_vec = -1;
  bit chk_en = 1'b0;

  alu_bist_seq #(.SETTLE_CYCLES(SETTLE), .SEED(SEED), .EXPECTED_SIG(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .s_out(s_out), .m_out(m_out), .ci_n_out(ci_n_out),
    .y_in(y_in), .p_in(p_in), .q_in(q_in), .co_n_in(co_n_in), .aeqb_in(aeqb_in),
    .signature(signature), .vec_cnt(vec_cnt), .pass(pass)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] r);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {8'h00, r};
  endfunction

  // Behavioural ALU: vector index -> {y, p, q, co_n, aeqb}
  function automatic logic [7:0] alu(input logic [13:0] v);
    logic [3:0] a, b, s, y;
    logic [4:0] sum;
    a   = v[3:0]; b = v[7:4]; s = v[11:8];
    sum = {1'b0, a} + {1'b0, b ^ s} + {4'd0, ~v[13]};
    y   = v[12] ? (a ^ b ^ s) : sum[3:0];
    return {y, &(a | b), |(a & b), ~sum[4], a == b};
  endfunction

  function automatic logic [7:0] resp_of(input logic [13:0] v);
    return alu(v) ^ ((int'(v) == fault_vec) ? 8'h80 : 8'h00);
  endfunction

  // Reference model: position within the sweep is a plain cycle count
  bit          m_run, m_done, m_pass;
  int          m_t;
  logic [13:0] m_vec;
  logic [15:0] m_sig;

  always @(posedge clk) begin : model
    bit          run_n, done_n, pass_n;
    int          t_n;
    logic [13:0] v_n;
    logic [15:0] s_n;
    run_n = m_run; done_n = m_done; pass_n = m_pass; t_n = m_t; v_n = m_vec; s_n = m_sig;
    if (!rst_n) begin
      run_n = 0; done_n = 0; pass_n = 0; t_n = 0; v_n = 0; s_n = SEED;
    end else if (!m_run && start) begin
      run_n = 1; done_n = 0; pass_n = 0; t_n = 0; v_n = 0; s_n = SEED;
    end else if (m_run) begin
      if (m_t % P == P - 1) begin
        s_n = misr(m_sig, resp_of(m_vec));
        if (m_vec == 14'h3FFF) begin
          run_n = 0; done_n = 1;
`ifdef ALU_BIST_PASS_CHECK_EN
          pass_n = (s_n == EXP);
`endif
        end
      end
      t_n = m_t + 1;
      if (run_n) v_n = 14'(t_n / P);
    end
    m_run <= run_n; m_done <= done_n; m_pass <= pass_n;
    m_t <= t_n; m_vec <= v_n; m_sig <= s_n;
  end

  // ALU response during the predicted capture cycle, noise otherwise
  always @(negedge clk) begin : resp_drv
    logic [7:0]  r;
    logic [13:0] v;
    v = {ci_n_out, m_out, s_out, b_out, a_out};
    if (m_run && (m_t % P == P - 1)) r = resp_of(v);
    else                             r = 8'($urandom);
    {y_in, p_in, q_in, co_n_in, aeqb_in} = r;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [46:0] got, want;
    if (chk_en) begin
      got  = {busy, done, pass, vec_cnt, a_out, b_out, s_out, m_out, ci_n_out, signature};
      want = {m_run, m_done, m_pass, m_vec, m_vec[3:0], m_vec[7:4], m_vec[11:8],
              m_vec[12], m_vec[13], m_sig};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL outs t=%0t got=%h want=%h", $time, got, want);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for the DUT to reach a vector, sprinkling ignored start pulses
  task automatic wait_vec(input int v, input string nm);
    int n = 0;
    while (vec_cnt != 14'(v) && n < 50000) begin
      start = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check(nm, vec_cnt, 64'(v));
  endtask

  initial begin
    int n;
    bit seen_ci;
    // Model pins
    check("misr_seed_ffff", misr(16'hFFFF, 8'h00), 16'hEFDF);
    check("misr_seed_0000", misr(16'h0000, 8'hFF), 16'h00FF);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_sig", signature, 16'hFFFF);
    check("rst_flags", {busy, done, pass, m_out, ci_n_out}, 0);
    check("rst_pins", {vec_cnt, a_out, b_out, s_out}, 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_sig", signature, 16'hFFFF);
    check("idle_busy", busy, 0);

    // Reset and start together: reset wins
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check("rst_beats_start", busy, 0);
    @(negedge clk);
    check("still_idle", busy, 0);

    // Partial sweep with one corrupted response, aborted at vector 5000
    fault_vec = $urandom_range(0, 4999);
    pulse_start();
    check("busy_after_start", busy, 1);
    check("a_first", a_out, 0);
    repeat (3) @(negedge clk);
    check("a_second", a_out, 1);
    wait_vec(16, "reach_v16");
    check("b_at_16", {b_out, a_out}, 8'h10);
    wait_vec(256, "reach_v256");
    check("s_at_256", {s_out, b_out, a_out}, 12'h100);
    wait_vec(4096, "reach_v4096");
    check("m_at_4096", {m_out, s_out}, 5'h10);
    wait_vec(5000, "reach_v5000");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_sig", signature, SEED);
    check("abort_vec", vec_cnt, 0);
    fault_vec = -1;
    repeat (4) @(negedge clk);

    // Full sweep, timed from the first DRIVE cycle
    pulse_start();
    n = 0;
    seen_ci = 1'b0;
    while (!done && n < 60000) begin
      start = ($urandom_range(0, 999) == 0);
      @(negedge clk);
      n++;
      if (n == 3) check("first_capture_sig", signature, misr(SEED, alu(14'd0)));
      if (!seen_ci && vec_cnt == 14'd8192) begin
        seen_ci = 1'b1;
        check("ci_at_8192", {ci_n_out, m_out}, 2'b10);
      end
    end
    start = 1'b0;
    check("sweep_cycles", n, 49152);
    check("done_vec", vec_cnt, 14'h3FFF);
    check("done_flags", {busy, done, pass}, 3'b010);
    check("done_sig_model", signature, m_sig);
    repeat (20) @(negedge clk);
    check("hold_vec", vec_cnt, 14'h3FFF);

    // Restart directly from DONE
    pulse_start();
    check("restart_flags", {busy, done}, 2'b10);
    check("restart_sig", signature, SEED);
    check("restart_vec", vec_cnt, 0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
